// File: rtl/mips_cpu_hilo_pkg.sv
// ---------------------------------------------------------------------------
// mips_cpu_hilo_pkg
//
// Shared types and helpers for the MIPS32 HI/LO multiply-divide controller.
//   hilo_op_t    : opcode presented by the execute stage on `op`
//   hilo_state_t : divide sequencing states of the controller
//   hilo_mul64() : 32x32->64 product, signed or unsigned
// ---------------------------------------------------------------------------
package mips_cpu_hilo_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    NOP   = 3'd0,
    MULT  = 3'd1,
    MULTU = 3'd2,
    DIV   = 3'd3,
    DIVU  = 3'd4,
    MTHI  = 3'd5,
    MTLO  = 3'd6
  } hilo_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } hilo_state_t;

  // Both operands are widened to 64 bits (sign- or zero-extended) before the
  // multiply; the low 64 bits of that product are the correct two's-complement
  // result in either mode, so one multiplier serves MULT and MULTU.
  function automatic logic [2*XLEN-1:0] hilo_mul64(
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b,
    input logic            is_signed
  );
    logic [2*XLEN-1:0] ext_a;
    logic [2*XLEN-1:0] ext_b;
    ext_a = {{XLEN{is_signed & a[XLEN-1]}}, a};
    ext_b = {{XLEN{is_signed & b[XLEN-1]}}, b};
    return ext_a * ext_b;
  endfunction

endpackage : mips_cpu_hilo_pkg

// File: rtl/mips_cpu_hilo_signfix.sv
// ---------------------------------------------------------------------------
// mips_cpu_hilo_signfix
//
// Purely combinational conditional negation of a pair of 32-bit values.
// Used twice by the controller:
//   - before the divider: absolute value (negate when the sign bit is set
//     and the op is signed)
//   - after the divider : restore the sign of quotient / remainder
//
// Ports
//   val_a_i, val_b_i : input values
//   neg_a_i, neg_b_i : negate the matching value when 1
//   res_a_o, res_b_o : results (two's-complement wrap, 0x80000000 stays put)
// ---------------------------------------------------------------------------
module mips_cpu_hilo_signfix
  import mips_cpu_hilo_pkg::*;
(
  input  logic [XLEN-1:0] val_a_i,
  input  logic [XLEN-1:0] val_b_i,
  input  logic            neg_a_i,
  input  logic            neg_b_i,
  output logic [XLEN-1:0] res_a_o,
  output logic [XLEN-1:0] res_b_o
);

  assign res_a_o = neg_a_i ? (~val_a_i + XLEN'(1)) : val_a_i;
  assign res_b_o = neg_b_i ? (~val_b_i + XLEN'(1)) : val_b_i;

endmodule : mips_cpu_hilo_signfix

// File: rtl/mips_cpu_hilo_ctrl.sv
// ---------------------------------------------------------------------------
// mips_cpu_hilo_ctrl
//
// HI/LO multiply-divide controller for the MIPS32 core. Owns the HI and LO
// registers, performs MULT/MULTU in one cycle, handles MTHI/MTLO, and
// sequences an external iterative unsigned divider for DIV/DIVU, converting
// signed operands to magnitudes on the way in and restoring signs on the way
// out.
//
// Ports
//   clk, reset           : clock, asynchronous active-low reset
//   op_valid, op         : op request (hilo_op_t), taken only when busy=0
//   op_a, op_b           : rs / rt operands
//   busy                 : divide in flight (registered, state != IDLE)
//   hi, lo               : architectural HI / LO
//   dbz                  : sticky divide-by-zero flag
//   div_start            : one-cycle start pulse to the divider
//   div_dividend/divisor : unsigned magnitudes, stable until write-back
//   div_done             : divider done (only looked at in WAIT)
//   div_quotient/remainder : unsigned divider results
//
// Build option
//   MIPS_CPU_HILO_DBZ_EN : when defined, a divide by zero sets dbz; the flag
//                          clears on the next accepted nonzero-divisor
//                          DIV/DIVU or on reset. Otherwise dbz is always 0.
// ---------------------------------------------------------------------------
module mips_cpu_hilo_ctrl
  import mips_cpu_hilo_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            dbz,
  output logic            div_start,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_divisor,
  input  logic            div_done,
  input  logic [XLEN-1:0] div_quotient,
  input  logic [XLEN-1:0] div_remainder
);

  hilo_state_t     state_q,    state_d;
  logic            busy_q,     busy_d;
  logic [XLEN-1:0] hi_q,       hi_d;
  logic [XLEN-1:0] lo_q,       lo_d;
  logic            dbz_q,      dbz_d;
  logic [XLEN-1:0] dividend_q, dividend_d;
  logic [XLEN-1:0] divisor_q,  divisor_d;
  logic            q_neg_q,    q_neg_d;
  logic            r_neg_q,    r_neg_d;

  hilo_op_t        op_e;
  logic            is_div_signed;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN-1:0] res_q, res_r;
  logic [2*XLEN-1:0] product;

  assign op_e          = hilo_op_t'(op);
  assign is_div_signed = (op_e == DIV);

  // Magnitudes for the divider. For DIVU both negate controls are 0, so the
  // raw operands pass straight through.
  mips_cpu_hilo_signfix u_pre_fix (
    .val_a_i (op_a),
    .val_b_i (op_b),
    .neg_a_i (is_div_signed & op_a[XLEN-1]),
    .neg_b_i (is_div_signed & op_b[XLEN-1]),
    .res_a_o (mag_a),
    .res_b_o (mag_b)
  );

  // Sign restoration of the divider results using the signs latched at accept.
  mips_cpu_hilo_signfix u_post_fix (
    .val_a_i (div_quotient),
    .val_b_i (div_remainder),
    .neg_a_i (q_neg_q),
    .neg_b_i (r_neg_q),
    .res_a_o (res_q),
    .res_b_o (res_r)
  );

  assign product = hilo_mul64(op_a, op_b, op_e == MULT);

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    dbz_d      = dbz_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;

    unique case (state_q)
      IDLE: begin
        if (op_valid) begin
          case (op_e)
            MULT, MULTU: begin
              hi_d = product[2*XLEN-1:XLEN];
              lo_d = product[XLEN-1:0];
            end
            MTHI: hi_d = op_a;
            MTLO: lo_d = op_a;
            DIV, DIVU: begin
              if (op_b != '0) begin
                dividend_d = mag_a;
                divisor_d  = mag_b;
                q_neg_d    = is_div_signed & (op_a[XLEN-1] ^ op_b[XLEN-1]);
                r_neg_d    = is_div_signed & op_a[XLEN-1];
                dbz_d      = 1'b0;
                state_d    = ISSUE;
              end else begin
`ifdef MIPS_CPU_HILO_DBZ_EN
                dbz_d = 1'b1;
`endif
              end
            end
            default: ;
          endcase
        end
      end

      // div_done is deliberately not looked at here: it may still be high
      // from the previous divide.
      ISSUE: state_d = WAIT;

      WAIT: begin
        if (div_done) begin
          lo_d    = res_q;
          hi_d    = res_r;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before the edge, independent of statement order.
  // All registers here are reset: the divider operands are visible outputs
  // and must read 0 out of reset, unlike a storage array which would not be.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      dbz_q      <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      dbz_q      <= dbz_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
    end
  end

  assign busy         = busy_q;
  assign hi           = hi_q;
  assign lo           = lo_q;
  assign dbz          = dbz_q;
  assign div_start    = (state_q == ISSUE);
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;

endmodule : mips_cpu_hilo_ctrl

// File: tb/tb_mips_cpu_hilo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_cpu_hilo_ctrl
//
// Self-checking bench for mips_cpu_hilo_ctrl with a behavioural 32-cycle
// divider beside the DUT and a reference model of HI/LO/dbz computed with
// plain 64-bit arithmetic. Inputs change and outputs are sampled on the
// falling clock edge.
// ---------------------------------------------------------------------------
module tb_mips_cpu_hilo_ctrl;
  import mips_cpu_hilo_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] op_a, op_b;
  logic        busy, dbz, div_start;
  logic [31:0] hi, lo, div_dividend, div_divisor;
  logic        div_done;
  logic [31:0] div_quotient, div_remainder;

  int n_pass  = 0;
  int n_total = 0;

  // reference model state
  logic [31:0] hi_m = 0, lo_m = 0;
  logic        dbz_m = 0;

  always #5 clk = ~clk;

  mips_cpu_hilo_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .op_valid      (op_valid),
    .op            (op),
    .op_a          (op_a),
    .op_b          (op_b),
    .busy          (busy),
    .hi            (hi),
    .lo            (lo),
    .dbz           (dbz),
    .div_start     (div_start),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_done      (div_done),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder)
  );

  // ---------------- behavioural divider (not reset by the core) ------------
  logic [31:0] m_a = 0, m_b = 1;
  int          m_cnt = 0;
  logic        m_done = 0;
  int          start_cnt = 0;

  always @(posedge clk) begin
    if (div_start) begin
      start_cnt <= start_cnt + 1;
      m_a <= div_dividend;
      m_b <= div_divisor;
      if (div_dividend == 0) begin
        m_cnt  <= 0;
        m_done <= 1'b1;
      end else begin
        m_cnt  <= 32;
        m_done <= 1'b0;
      end
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_done <= 1'b1;
    end
  end

  assign div_done      = m_done;
  assign div_quotient  = (m_b == 0) ? 32'd0 : m_a / m_b;
  assign div_remainder = (m_b == 0) ? 32'd0 : m_a % m_b;

  // ---------------- reference model ----------------------------------------
  task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int              sa, sb;
    longint          sp, sq, sr;
    longint unsigned up;
    sa = a;
    sb = b;
    case (o)
      3'd1: begin sp = longint'(sa) * longint'(sb); hi_m = sp[63:32]; lo_m = sp[31:0]; end
      3'd2: begin up = {32'd0, a} * {32'd0, b}; hi_m = up[63:32]; lo_m = up[31:0]; end
      3'd3, 3'd4: begin
        if (b != 0) begin
          if (o == 3'd3) begin
            sq = longint'(sa) / longint'(sb);
            sr = longint'(sa) % longint'(sb);
            lo_m = sq[31:0];
            hi_m = sr[31:0];
          end else begin
            lo_m = a / b;
            hi_m = a % b;
          end
          dbz_m = 1'b0;
        end else begin
`ifdef MIPS_CPU_HILO_DBZ_EN
          dbz_m = 1'b1;
`endif
        end
      end
      3'd5: hi_m = a;
      3'd6: lo_m = a;
      default: ;
    endcase
  endtask

  // ---------------- stimulus helpers ----------------------------------------
  // Presents an op for one cycle; returns at the falling edge after the
  // accept edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_valid = 1'b1;
    op       = o;
    op_a     = a;
    op_b     = b;
    @(negedge clk);
    op_valid = 1'b0;
    op       = 3'd0;
  endtask

  // Counts falling edges with busy high, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic check_state(input string name);
    n_total++;
    if (hi !== hi_m) $display("FAIL %s hi: got %h expected %h", name, hi, hi_m);
    else n_pass++;
    n_total++;
    if (lo !== lo_m) $display("FAIL %s lo: got %h expected %h", name, lo, lo_m);
    else n_pass++;
    n_total++;
    if (dbz !== dbz_m) $display("FAIL %s dbz: got %b expected %b", name, dbz, dbz_m);
    else n_pass++;
  endtask

  // ---------------- tests ----------------------------------------------------
  task automatic test_reset();
    reset = 1'b0; op_valid = 1'b0; op = 3'd0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || div_start !== 1'b0) $display("FAIL reset_ctrl: busy=%b start=%b expected 0/0", busy, div_start);
    else n_pass++;
    n_total++;
    if (div_dividend !== 32'd0 || div_divisor !== 32'd0)
      $display("FAIL reset_divops: dividend=%h divisor=%h expected 0/0", div_dividend, div_divisor);
    else n_pass++;
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check_state("reset_idle");
    n_total++;
    if (start_cnt !== 0 || busy !== 1'b0) $display("FAIL idle_no_start: starts=%0d busy=%b expected 0/0", start_cnt, busy);
    else n_pass++;
  endtask

  task automatic test_mult();
    issue(MULT, 32'hFFFF_FFFE, 32'd3);
    model_op(MULT, 32'hFFFF_FFFE, 32'd3);
    n_total++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) $display("FAIL mult: got %h_%h expected ffffffff_fffffffa", hi, lo);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL mult_busy: got %b expected 0", busy);
    else n_pass++;
    issue(MULTU, 32'hFFFF_FFFE, 32'd3);
    model_op(MULTU, 32'hFFFF_FFFE, 32'd3);
    n_total++;
    if (hi !== 32'h0000_0002 || lo !== 32'hFFFF_FFFA) $display("FAIL multu: got %h_%h expected 00000002_fffffffa", hi, lo);
    else n_pass++;
    issue(MTHI, 32'h1234, 32'd0);
    model_op(MTHI, 32'h1234, 32'd0);
    n_total++;
    if (hi !== 32'h1234) $display("FAIL mthi: got %h expected 00001234", hi);
    else n_pass++;
  endtask

  task automatic test_div_signed();
    int s0, n;
    s0 = start_cnt;
    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    model_op(DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    n_total++;
    if (n != 34) $display("FAIL div_busy_cycles: got %0d expected 34", n);
    else n_pass++;
    n_total++;
    if (start_cnt - s0 != 1) $display("FAIL div_start_pulses: got %0d expected 1", start_cnt - s0);
    else n_pass++;
    n_total++;
    if (m_a !== 32'd7 || m_b !== 32'd2) $display("FAIL div_operands: got %0d/%0d expected 7/2", m_a, m_b);
    else n_pass++;
    n_total++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) $display("FAIL div_neg7_2: got hi=%h lo=%h expected ffffffff/fffffffd", hi, lo);
    else n_pass++;
    // two's-complement wrap corner
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    model_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    n_total++;
    if (lo !== 32'h8000_0000 || hi !== 32'd0) $display("FAIL div_wrap: got hi=%h lo=%h expected 00000000/80000000", hi, lo);
    else n_pass++;
  endtask

  task automatic test_divu_and_zero_dividend();
    int n;
    issue(DIVU, 32'hFFFF_FFF9, 32'd2);
    model_op(DIVU, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    n_total++;
    if (lo !== 32'h7FFF_FFFC || hi !== 32'd1) $display("FAIL divu: got hi=%h lo=%h expected 00000001/7ffffffc", hi, lo);
    else n_pass++;
    // divider done is still high from the DIVU above
    issue(MTHI, 32'hAAAA_0001, 32'd0); model_op(MTHI, 32'hAAAA_0001, 32'd0);
    issue(MTLO, 32'h5555_0002, 32'd0); model_op(MTLO, 32'h5555_0002, 32'd0);
    issue(DIV, 32'd0, 32'd5);
    @(negedge clk); // after A+1
    n_total++;
    if (busy !== 1'b1 || hi !== 32'hAAAA_0001 || lo !== 32'h5555_0002)
      $display("FAIL div0_early: busy=%b hi=%h lo=%h expected 1/aaaa0001/55550002", busy, hi, lo);
    else n_pass++;
    model_op(DIV, 32'd0, 32'd5);
    @(negedge clk); // after A+2
    n_total++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) $display("FAIL div0_wb: busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
    else n_pass++;
  endtask

  task automatic test_div_by_zero();
    int s0, n;
    s0 = start_cnt;
    issue(DIV, 32'd77, 32'd0);
    model_op(DIV, 32'd77, 32'd0);
    repeat (3) @(negedge clk);
    n_total++;
    if (start_cnt != s0 || busy !== 1'b0) $display("FAIL dbz_no_start: starts=%0d busy=%b expected 0/0", start_cnt - s0, busy);
    else n_pass++;
    check_state("dbz_set");
    issue(DIV, 32'd6, 32'd3);
    n_total++;
    if (dbz !== 1'b0) $display("FAIL dbz_clear: got %b expected 0", dbz);
    else n_pass++;
    model_op(DIV, 32'd6, 32'd3);
    wait_idle(n);
    check_state("div_6_3");
  endtask

  task automatic test_reset_mid_div();
    issue(MTHI, 32'h55, 32'd0);
    model_op(MTHI, 32'h55, 32'd0);
    issue(DIV, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    n_total++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || div_start !== 1'b0)
      $display("FAIL reset_mid: busy=%b hi=%h lo=%h start=%b expected all 0", busy, hi, lo, div_start);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    hi_m = 0; lo_m = 0; dbz_m = 0;
    repeat (40) @(negedge clk);
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_late_busy: got %b expected 0", busy);
    else n_pass++;
    check_state("reset_late_done");
  endtask

  task automatic test_busy_ignore();
    int n;
    issue(DIVU, 32'd1000, 32'd9);
    model_op(DIVU, 32'd1000, 32'd9);
    repeat (4) @(negedge clk);
    op_valid = 1'b1; op = MTLO; op_a = 32'hDEAD_BEEF; op_b = 32'd0;
    @(negedge clk);
    op_valid = 1'b0; op = 3'd0;
    n_total++;
    if (lo === 32'hDEAD_BEEF) $display("FAIL busy_mtlo: got %h expected not deadbeef", lo);
    else n_pass++;
    wait_idle(n);
    check_state("busy_ignore");
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b;
    int          n;
    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(0, 6));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'd0;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) a = 32'd0;
      issue(o, a, b);
      model_op(o, a, b);
      wait_idle(n);
      n_total++;
      if (busy !== 1'b0) $display("FAIL rand_timeout op=%0d: busy=%b expected 0", o, busy);
      else n_pass++;
      check_state($sformatf("rand%0d_op%0d", i, o));
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div_signed();
    test_divu_and_zero_dividend();
    test_div_by_zero();
    test_reset_mid_div();
    test_busy_ignore();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_mips_cpu_hilo_ctrl

// File: doc/mips_cpu_hilo_ctrl.md
# mips_cpu_hilo_ctrl

HI/LO multiply-divide controller for the MIPS32 core. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage, owns the architectural HI and LO registers, and sequences the external iterative unsigned divider, handling signed operands around it. Asserts `busy` while a divide is in flight so the core can stall MFHI/MFLO and further HI/LO ops.

## Interface
Parameters: none.
- `clk`  in  1  core clock
- `reset`  in  1  asynchronous, active-low reset
- `op_valid`  in  1  op request, accepted only when `busy`=0
- `op`  in  3  `hilo_op_t` opcode
- `op_a`, `op_b`  in  32 each  rs / rt operands
- `busy`  out  1  divide in progress
- `hi`, `lo`  out  32 each  architectural HI/LO
- `dbz`  out  1  divide-by-zero flag (see Configuration)
- `div_start`  out  1  one-cycle start pulse to the divider
- `div_dividend`, `div_divisor`  out  32 each  unsigned magnitudes to the divider
- `div_done`  in  1  divider done
- `div_quotient`, `div_remainder`  in  32 each  divider results

## Operation
- Reset values: `hi`=`lo`=0, `busy`=0, `dbz`=0, `div_start`=0, `div_dividend`=`div_divisor`=0, state IDLE.
- States: IDLE, ISSUE, WAIT.
- IDLE, `op_valid`=1:
  - MULT/MULTU: signed/unsigned 32×32→64 product. {HI,LO} written on the accept edge. Stays in IDLE.
  - MTHI/MTLO: `op_a`→HI or LO on the accept edge.
  - NOP: ignored.
  - DIV/DIVU, `op_b`≠0: latch |a|, |b| (DIV) or raw operands (DIVU), plus `q_neg` = sign(a)^sign(b) and `r_neg` = sign(a) (both 0 for DIVU). Go to ISSUE.
  - DIV/DIVU, `op_b`=0: divider not started. HI/LO unchanged. Stays in IDLE.
- ISSUE: `div_start`=1 for exactly this cycle; operands held. Go to WAIT.
- WAIT: sample `div_done` every cycle. `div_done` is never sampled in the ISSUE cycle, because it may still hold a stale 1 from the previous op. On `div_done`=1:
  - LO = `q_neg` ? −quotient : quotient
  - HI = `r_neg` ? −remainder : remainder
  - Go to IDLE.
- Signed corner case: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (two's-complement wrap, no trap).
- `op_valid` while `busy`=1 is ignored with no side effects.
- `div_dividend`/`div_divisor` stay stable from ISSUE until the write-back edge.

## Timing
- `busy` is registered and equals (state≠IDLE): high from the edge after DIV/DIVU accept until the write-back edge.
- MULT/MULTU/MTHI/MTLO: `hi`/`lo` valid one edge after accept. `busy` stays 0.
- DIV/DIVU with nonzero divisor, accept edge A:
  - `div_start` is high during cycle A→A+1.
  - Divider asserts done after edge A+33; HI/LO are written at edge A+34; `busy` drops at A+34.
  - Zero dividend: the divider finishes immediately, so HI/LO are written at A+2.
- Reset mid-divide: immediate return to IDLE, outputs take reset values. Any later `div_done` is ignored because the controller is back in IDLE.

## Configuration
- `MIPS_CPU_HILO_DBZ_EN` defined:
  - A divide by zero sets `dbz`=1 on the accept edge; HI/LO unchanged.
  - `dbz` is sticky and clears on the next accepted DIV/DIVU with nonzero divisor, or on reset.
- Undefined: `dbz` tied 0; divide by zero is a silent no-op on HI/LO.

## Structure
- Package `mips_cpu_hilo_pkg`:
  - `hilo_op_t` enum: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
  - `hilo_state_t` enum: IDLE, ISSUE, WAIT.
- Sub-module `mips_cpu_hilo_signfix`: purely combinational, two instances.
  - Pre-divide: absolute value.
  - Post-divide: conditional negate.
- The divider is instantiated beside this block, not inside it. Its `reset` is driven from the core reset.

## Test plan
- Reset, then idle with `op_valid`=0 → `hi`=`lo`=0, `busy`=0, `div_start` never asserted.
- MULT a=0xFFFFFFFE, b=3 → HI=0xFFFFFFFF, LO=0xFFFFFFFA next edge. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA. MTHI 0x1234 → HI=0x1234.
- DIV a=0xFFFFFFF9 (−7), b=2 with a behavioural divider model:
  - Exactly one `div_start` pulse; divider sees 7 and 2.
  - `busy` high for 34 cycles.
  - LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=0xFFFFFFF9, b=2 → LO=0x7FFFFFFC, HI=1. DIV a=0 → HI=LO=0 two edges after accept; the stale `div_done`=1 in the ISSUE cycle is not taken.
- DIV b=0:
  - Macro defined → no `div_start`, `dbz`=1, HI/LO unchanged; a following DIV 6/3 clears `dbz`.
  - Macro undefined → `dbz`=0.
- Reset mid-divide and ignored requests:
  - Pulse `reset` low 10 cycles into a divide → `busy`=0 and HI/LO=0 immediately; the later `div_done` causes no write.
  - `op_valid` with MTLO while `busy` → LO unchanged.
